// File: rtl/regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_sched
// Purpose  : Shares the register-file write port between two valid/ready
//            requesters and runs an init sequence that fills every register.
// Options  : RR_ARB_EN - round-robin arbitration (fixed priority otherwise)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              init_start,
  input  logic [DATA_W-1:0] init_value,
  output logic              busy,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  output logic              grant_id
);

  localparam int                NUM_REGS   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_INIT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_init_val, w_init_val_nxt;
  logic              r_regwrite, w_regwrite_nxt;
  logic [ADDR_W-1:0] r_writereg, w_writereg_nxt;
  logic [DATA_W-1:0] r_writedata, w_writedata_nxt;
  logic              r_grant_id, w_grant_id_nxt;
  logic              w_ready0, w_ready1;

`ifdef RR_ARB_EN
  logic              r_ptr;
`endif

  // Grants only in IDLE, and never in the cycle an init is launched.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (r_state == S_IDLE && !init_start) begin
`ifdef RR_ARB_EN
      if (req0_valid && (!req1_valid || !r_ptr)) w_ready0 = 1'b1;
      else if (req1_valid)                       w_ready1 = 1'b1;
`else
      if (req0_valid)      w_ready0 = 1'b1;
      else if (req1_valid) w_ready1 = 1'b1;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_init_val_nxt  = r_init_val;
    w_regwrite_nxt  = 1'b0;
    w_writereg_nxt  = r_writereg;
    w_writedata_nxt = r_writedata;
    w_grant_id_nxt  = r_grant_id;
    case (r_state)
      S_IDLE: begin
        if (init_start) begin
          w_state_nxt    = S_INIT;
          w_cnt_nxt      = '0;
          w_init_val_nxt = init_value;
        end else if (w_ready0) begin
          w_regwrite_nxt  = 1'b1;
          w_writereg_nxt  = req0_reg;
          w_writedata_nxt = req0_data;
          w_grant_id_nxt  = 1'b0;
        end else if (w_ready1) begin
          w_regwrite_nxt  = 1'b1;
          w_writereg_nxt  = req1_reg;
          w_writedata_nxt = req1_data;
          w_grant_id_nxt  = 1'b1;
        end
      end
      S_INIT: begin
        w_regwrite_nxt  = 1'b1;
        w_writereg_nxt  = r_cnt;
        w_writedata_nxt = r_init_val;
        w_cnt_nxt       = r_cnt + ADDR_W'(1);
        if (r_cnt == c_last_reg) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_init_val  <= '0;
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
      r_grant_id  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_val  <= w_init_val_nxt;
      r_regwrite  <= w_regwrite_nxt;
      r_writereg  <= w_writereg_nxt;
      r_writedata <= w_writedata_nxt;
      r_grant_id  <= w_grant_id_nxt;
    end
  end

`ifdef RR_ARB_EN
  // Pointer favours whichever requester was not served last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_ptr <= 1'b0;
    else if (w_ready0) r_ptr <= 1'b1;
    else if (w_ready1) r_ptr <= 1'b0;
  end
`endif

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign busy       = (r_state == S_INIT);
  assign regwrite   = r_regwrite;
  assign writereg   = r_writereg;
  assign writedata  = r_writedata;
  assign grant_id   = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
`default_nettype none
// Testbench for regfile_wr_sched: scoreboard of expected write-port activity.
module tb_regfile_wr_sched;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_reg, req1_reg, writereg;
  logic [DATA_W-1:0] req0_data, req1_data, init_value, writedata;
  logic              init_start, busy, regwrite, grant_id;

  regfile_wr_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .init_start(init_start), .init_value(init_value), .busy(busy),
    .regwrite(regwrite), .writereg(writereg), .writedata(writedata), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    logic              g;
    int                c;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic m_ptr = 1'b0;
  logic m_gid = 1'b0;
  int   m_init_rem = 0;
  logic e_rdy0 = 1'b0, e_rdy1 = 1'b0, e_busy = 1'b0;
  bit   mon_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake/busy expectations and write-port scoreboard.
  always @(negedge clk) begin
    if (mon_chk) begin
      checks++;
      if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1 || busy !== e_busy) begin
        errors++;
        $display("FAIL ready_busy cyc=%0d: got r0=%b r1=%b busy=%b, expected r0=%b r1=%b busy=%b",
                 cyc, req0_ready, req1_ready, busy, e_rdy0, e_rdy1, e_busy);
      end
    end
    if (reset === 1'b1) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        m_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write cyc=%0d: got none, expected reg=%0d data=%h in cyc %0d",
                 cyc, m_e.r, m_e.d, m_e.c);
      end
      if (regwrite !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d: got regwrite=%b reg=%0d data=%h, expected no write",
                   cyc, regwrite, writereg, writedata);
        end else begin
          m_e = q.pop_front();
          if (regwrite !== 1'b1 || writereg !== m_e.r || writedata !== m_e.d ||
              grant_id !== m_e.g || cyc != m_e.c) begin
            errors++;
            $display("FAIL write cyc=%0d: got reg=%0d data=%h gid=%b, expected reg=%0d data=%h gid=%b cyc=%0d",
                     cyc, writereg, writedata, grant_id, m_e.r, m_e.d, m_e.g, m_e.c);
          end
        end
      end
    end
  end

  // Drives one cycle of stimulus and records what the scheduler should do with it.
  task automatic drive(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                       input logic st, input logic [DATA_W-1:0] iv);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    init_start = st; init_value = iv;
    e_busy = (m_init_rem != 0);
    e_rdy0 = 1'b0;
    e_rdy1 = 1'b0;
    if (m_init_rem != 0) begin
      m_init_rem--;
    end else if (st) begin
      m_init_rem = 4;
      for (int k = 0; k < 4; k++) q.push_back('{r: ADDR_W'(k), d: iv, g: m_gid, c: cyc + 2 + k});
    end else begin
`ifdef RR_ARB_EN
      if (v0 && (!v1 || !m_ptr)) e_rdy0 = 1'b1;
      else if (v1)               e_rdy1 = 1'b1;
`else
      if (v0)      e_rdy0 = 1'b1;
      else if (v1) e_rdy1 = 1'b1;
`endif
      if (e_rdy0) begin
        m_gid = 1'b0; m_ptr = 1'b1;
        q.push_back('{r: r0, d: d0, g: 1'b0, c: cyc + 1});
      end
      if (e_rdy1) begin
        m_gid = 1'b1; m_ptr = 1'b0;
        q.push_back('{r: r1, d: d1, g: 1'b1, c: cyc + 1});
      end
    end
    mon_chk = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    q.delete();
    m_ptr = 1'b0; m_gid = 1'b0; m_init_rem = 0;
    mon_chk = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    init_start = 1'b0; init_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b, expected 0", regwrite); end
    checks++; if (writereg !== '0) begin errors++; $display("FAIL reset_writereg: got %0d, expected 0", writereg); end
    checks++; if (writedata !== '0) begin errors++; $display("FAIL reset_writedata: got %h, expected 0", writedata); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b, expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    for (int i = 0; i < 4; i++)
      drive(1'b1, ADDR_W'(i), 32'hA000_0000 + i, 1'b1, ADDR_W'(3 - i), 32'hB000_0000 + i, 1'b0, '0);
    checks++;
`ifdef RR_ARB_EN
    if (writedata !== 32'hB000_0003 || grant_id !== 1'b1) begin
      errors++; $display("FAIL contention_last: got data=%h gid=%b, expected data=b0000003 gid=1", writedata, grant_id);
    end
`else
    if (writedata !== 32'hA000_0003 || grant_id !== 1'b0) begin
      errors++; $display("FAIL contention_last: got data=%h gid=%b, expected data=a0000003 gid=0", writedata, grant_id);
    end
`endif
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_single_write;
    drive(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (regwrite !== 1'b1 || writereg !== 2'd2 || writedata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write: got we=%b reg=%0d data=%h, expected we=1 reg=2 data=deadbeef",
                         regwrite, writereg, writedata);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (regwrite !== 1'b0 || writereg !== 2'd2 || writedata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_hold: got we=%b reg=%0d data=%h, expected we=0 reg=2 data=deadbeef",
                         regwrite, writereg, writedata);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, '0, '0, 1'b1, 2'd1, 32'h1111_1111, 1'b0, '0);
    drive(1'b1, 2'd1, 32'h2222_2222, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (writereg !== 2'd1 || writedata !== 32'h2222_2222 || grant_id !== 1'b0) begin
      errors++; $display("FAIL back_to_back_last: got reg=%0d data=%h gid=%b, expected reg=1 data=22222222 gid=0",
                         writereg, writedata, grant_id);
    end
  endtask

  task automatic test_init;
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b1, 32'h5A5A_5A5A);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy_rise: got %b, expected 1", busy); end
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b0, 32'h1234_5678);
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b1, 32'h1234_5678);
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b0, 32'h1234_5678);
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b0, 32'h1234_5678);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_fall: got %b, expected 0", busy); end
    drive(1'b0, '0, '0, 1'b1, 2'd3, 32'hC0FF_EE00, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_init_reset;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'h7777_7777);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    #6;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (regwrite !== 1'b0 || busy !== 1'b0 || writereg !== '0 || writedata !== '0) begin
      errors++; $display("FAIL init_reset: got we=%b busy=%b reg=%0d data=%h, expected all 0",
                         regwrite, busy, writereg, writedata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      checks++;
      if (regwrite !== 1'b0) begin errors++; $display("FAIL init_abandoned: got regwrite=%b, expected 0", regwrite); end
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 2'd3, 32'h0F0F_0F0F, 1'b0, '0, '0, 1'b0, '0);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (regwrite !== 1'b0 || writereg !== '0 || writedata !== '0 || grant_id !== 1'b0) begin
      errors++; $display("FAIL midstream_reset: got we=%b reg=%0d data=%h gid=%b, expected all 0",
                         regwrite, writereg, writedata, grant_id);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 2'd1, 32'hAAAA_0001, 1'b1, 2'd2, 32'hBBBB_0002, 1'b0, '0);
    checks++;
    if (grant_id !== 1'b0 || writedata !== 32'hAAAA_0001) begin
      errors++; $display("FAIL first_after_reset: got gid=%b data=%h, expected gid=0 data=aaaa0001", grant_id, writedata);
    end
    drive(1'b1, 2'd1, 32'hAAAA_0003, 1'b1, 2'd2, 32'hBBBB_0002, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_back_to_back();
    test_init();
    test_init_reset();
    test_reset_midstream();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", q.size());
    end
    mon_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
